// File: rtl/stack_unit_pkg.sv
// Shared CPU package: the stack opcodes used by the instruction decoder
// and by stack_unit.
package stack_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_DUP  = 3'b011,
        OP_SWAP = 3'b100
    } op_e;

endpackage : stack_unit_pkg

// File: rtl/stack_unit_if.sv
// Bus between the decoder (master) and the stack unit (slave): the opcode
// and operand in, registered stack state out.
interface stack_unit_if #(
    parameter int WIDTH = 8
) ();

    logic [2:0]       op;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] stack_output;
    logic [WIDTH-1:0] temp1;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
        output op, push_data,
        input  stack_output, temp1, empty, full, err
    );

    modport slave (
        input  op, push_data,
        output stack_output, temp1, empty, full, err
    );

endinterface : stack_unit_if

// File: rtl/stack_unit_regfile.sv
// Stack storage: one write port and two read ports that return the top and
// second entries of the array, whose fill level is given by i_level.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_level,
    output logic [WIDTH-1:0]         o_rd_top,
    output logic [WIDTH-1:0]         o_rd_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; the level and the gating in stack_unit
    // keep unwritten entries away from the outputs.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rd_top  = r_mem[i_level - AW'(1)];
    assign o_rd_next = r_mem[i_level - AW'(2)];

endmodule : stack_regfile

// File: rtl/stack_unit.sv
// Hardware stack. TOS and NOS are held in output registers; the array below
// TOS holds entries 0..count-2, so every op needs at most one array write.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    stack_unit_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_tos;
    logic [WIDTH-1:0] r_nos;
    logic             r_empty;
    logic             r_full;
    logic             r_err;

    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_tos_nxt;
    logic [WIDTH-1:0] w_nos_nxt;
    logic             w_illegal;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_level;
    logic [WIDTH-1:0] w_rd_top;
    logic [WIDTH-1:0] w_rd_next;

    // Entries in the array are everything below TOS: count-1 of them.
    assign w_level = AW'(r_count - CW'(1));

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (r_tos),
        .i_level   (w_level),
        .o_rd_top  (w_rd_top),
        .o_rd_next (w_rd_next)
    );

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        w_count_nxt = r_count;
        w_tos_nxt   = r_tos;
        w_nos_nxt   = r_nos;
        w_illegal   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = AW'(r_count - CW'(1));
        case (bus.op)
            OP_PUSH: begin
                if (r_count == C_DEPTH) begin
                    w_illegal = 1'b1;
                end else begin
                    w_we        = (r_count != '0);
                    w_count_nxt = r_count + CW'(1);
                    w_tos_nxt   = bus.push_data;
                    w_nos_nxt   = r_tos;
                end
            end
            OP_POP: begin
                if (r_count == '0) begin
                    w_illegal = 1'b1;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                    w_tos_nxt   = (r_count >= CW'(2)) ? w_rd_top  : '0;
                    w_nos_nxt   = (r_count >= CW'(3)) ? w_rd_next : '0;
                end
            end
            OP_DUP: begin
                if (r_count == '0 || r_count == C_DEPTH) begin
                    w_illegal = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                    w_nos_nxt   = r_tos;
                end
            end
            OP_SWAP: begin
                if (r_count < CW'(2)) begin
                    w_illegal = 1'b1;
                end else begin
                    // Old TOS becomes NOS and must also land in the array slot.
                    w_we      = 1'b1;
                    w_waddr   = AW'(r_count - CW'(2));
                    w_tos_nxt = r_nos;
                    w_nos_nxt = r_tos;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tos   <= '0;
            r_nos   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tos   <= w_tos_nxt;
            r_nos   <= w_nos_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == C_DEPTH);
            r_err   <= r_err | w_illegal;
        end
    end

    assign bus.stack_output = r_tos;
    assign bus.temp1        = r_nos;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.err          = r_err;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a queue-based stack model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_stack_unit;
    import stack_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;
    bit   chk_en;

    logic [WIDTH-1:0] m_q[$];
    bit               m_err;

    stack_unit_if #(.WIDTH(WIDTH)) bus ();

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_tos();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_nos();
        return (m_q.size() > 1) ? m_q[m_q.size()-2] : '0;
    endfunction

    // Stack semantics straight from the opcode rules.
    task automatic model_step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic rst_n);
        logic [WIDTH-1:0] t;
        int n;
        n = m_q.size();
        if (!rst_n) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            case (o)
                3'b001: if (n == DEPTH) m_err = 1'b1; else m_q.push_back(d);
                3'b010: if (n == 0) m_err = 1'b1; else void'(m_q.pop_back());
                3'b011: if (n == 0 || n == DEPTH) m_err = 1'b1; else m_q.push_back(m_q[n-1]);
                3'b100: begin
                    if (n < 2) m_err = 1'b1;
                    else begin
                        t = m_q[n-1];
                        m_q[n-1] = m_q[n-2];
                        m_q[n-2] = t;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic rst_n);
        bus.op        = o;
        bus.push_data = d;
        reset         = rst_n;
        @(posedge clk);
        model_step(o, d, rst_n);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("tos",   {24'h0, bus.stack_output}, {24'h0, m_tos()});
            check("nos",   {24'h0, bus.temp1},        {24'h0, m_nos()});
            check("empty", {31'h0, bus.empty},        {31'h0, (m_q.size() == 0)});
            check("full",  {31'h0, bus.full},         {31'h0, (m_q.size() == DEPTH)});
            check("err",   {31'h0, bus.err},          {31'h0, m_err});
            check("count", {27'h0, dut.r_count},      m_q.size());
        end
    end

    initial begin
        int r;
        bit push_heavy;
        logic [2:0] o;
        n_checks = 0;
        n_fails  = 0;
        m_err    = 1'b0;
        chk_en   = 1'b1;
        bus.op        = OP_NOP;
        bus.push_data = '0;
        reset         = 1'b0;

        // Reset held for two cycles.
        do_op(OP_NOP, 8'h00, 1'b0);
        do_op(OP_NOP, 8'h00, 1'b0);
        do_op(OP_NOP, 8'h00, 1'b1);
        check("rst_empty", {31'h0, bus.empty}, 32'd1);
        check("rst_full",  {31'h0, bus.full},  32'd0);
        check("rst_err",   {31'h0, bus.err},   32'd0);
        check("rst_tos",   {24'h0, bus.stack_output}, 32'h0);
        check("rst_nos",   {24'h0, bus.temp1}, 32'h0);

        // PUSH, PUSH, SWAP, POP.
        do_op(OP_PUSH, 8'h11, 1'b1);
        do_op(OP_PUSH, 8'h22, 1'b1);
        do_op(OP_SWAP, 8'h00, 1'b1);
        check("swap_tos", {24'h0, bus.stack_output}, 32'h11);
        check("swap_nos", {24'h0, bus.temp1}, 32'h22);
        do_op(OP_POP, 8'h00, 1'b1);
        check("pop_tos",   {24'h0, bus.stack_output}, 32'h22);
        check("pop_nos",   {24'h0, bus.temp1}, 32'h0);
        check("pop_count", {27'h0, dut.r_count}, 32'd1);

        // Fill to the brim, then overflow.
        do_op(OP_NOP, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, 8'(i), 1'b1);
        check("fill_full", {31'h0, bus.full}, 32'd1);
        check("fill_err",  {31'h0, bus.err},  32'd0);
        do_op(OP_PUSH, 8'hAA, 1'b1);
        check("ovf_tos",  {24'h0, bus.stack_output}, 32'h0F);
        check("ovf_nos",  {24'h0, bus.temp1}, 32'h0E);
        check("ovf_err",  {31'h0, bus.err},  32'd1);
        check("ovf_full", {31'h0, bus.full}, 32'd1);
        // Drain fully to exercise every refill read.
        for (int i = 0; i < DEPTH; i++) do_op(OP_POP, 8'h00, 1'b1);
        check("drain_empty", {31'h0, bus.empty}, 32'd1);

        // Underflow, then err stays sticky across a legal push.
        do_op(OP_NOP, 8'h00, 1'b0);
        do_op(OP_POP, 8'h00, 1'b1);
        check("udf_err", {31'h0, bus.err}, 32'd1);
        do_op(OP_PUSH, 8'h5A, 1'b1);
        check("sticky_err",   {31'h0, bus.err}, 32'd1);
        check("sticky_tos",   {24'h0, bus.stack_output}, 32'h5A);
        check("sticky_empty", {31'h0, bus.empty}, 32'd0);

        // DUP twice, then a reserved opcode.
        do_op(OP_NOP, 8'h00, 1'b0);
        do_op(OP_PUSH, 8'h33, 1'b1);
        do_op(OP_DUP, 8'h00, 1'b1);
        do_op(OP_DUP, 8'h00, 1'b1);
        do_op(3'b111, 8'hFF, 1'b1);
        check("dup_tos",   {24'h0, bus.stack_output}, 32'h33);
        check("dup_nos",   {24'h0, bus.temp1}, 32'h33);
        check("dup_count", {27'h0, dut.r_count}, 32'd3);
        check("dup_err",   {31'h0, bus.err}, 32'd0);

        // Reset wins over a PUSH on the same edge.
        do_op(OP_PUSH, 8'h44, 1'b0);
        check("rstpri_empty", {31'h0, bus.empty}, 32'd1);
        check("rstpri_tos",   {24'h0, bus.stack_output}, 32'h0);
        check("rstpri_err",   {31'h0, bus.err}, 32'd0);

        // Random traffic, alternating fill-biased and drain-biased phases.
        push_heavy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) push_heavy = ~push_heavy;
            r = $urandom_range(0, 99);
            if (r < 35)      o = push_heavy ? OP_PUSH : OP_POP;
            else if (r < 55) o = push_heavy ? OP_POP : OP_PUSH;
            else if (r < 70) o = OP_DUP;
            else if (r < 88) o = OP_SWAP;
            else             o = 3'($urandom_range(0, 7));
            do_op(o, 8'($urandom), ($urandom_range(0, 199) != 0));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_stack_unit
